pipe_fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the five-stage pipelined MIPS core, including the IF/ID pipeline register. It holds the PC, selects the next PC from the decode stage's `pcsource`/`bpc`/`jpc`/register target, and fetches from an instruction memory that may insert wait states. It presents `dpc4`/`inst` to the decode stage. Branches and jumps resolve in ID with one architectural delay slot. A pending-redirect register ensures a redirect issued while the delay-slot fetch is waiting on memory is never lost.

---
 rtl/pipe_fetch_stage_if.sv | 19 +
 rtl/pipe_fetch_stage.sv | 72 +++++++
 tb/tb_pipe_fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and its instruction memory.
// The fetch side drives the address; memory returns the word and its ready flag.
interface pipe_fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_inst;

  modport master (
    output imem_addr,
    input  imem_ready,
    input  imem_inst
  );

  modport slave (
    input  imem_addr,
    output imem_ready,
    output imem_inst
  );
endinterface

// File: rtl/pipe_fetch_stage.sv
// IF stage with IF/ID register for the five-stage MIPS core.
// A pending-redirect register keeps a branch target alive across fetch wait states.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [1:0]                pcsource,
  input  logic [31:0]               bpc,
  input  logic [31:0]               rpc,
  input  logic [31:0]               jpc,
  input  logic                      wpcir,
  pipe_fetch_stage_if.master        imem,
  output logic [31:0]               pc,
  output logic [31:0]               dpc4,
  output logic [31:0]               inst,
  output logic                      pend
);

  logic [31:0] r_pc;
  logic [31:0] r_dpc4;
  logic [31:0] r_inst;
  logic        r_pend;
  logic [31:0] r_pend_pc;

  logic [31:0] w_pc4;
  logic [31:0] w_sel;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_sel = w_pc4;
    unique case (pcsource)
      2'b00: w_sel = w_pc4;
      2'b01: w_sel = bpc;
      2'b10: w_sel = rpc;
      2'b11: w_sel = jpc;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_dpc4    <= 32'd0;
      r_inst    <= NOP_INST;
      r_pend    <= 1'b0;
      r_pend_pc <= 32'd0;
    end else if (wpcir) begin
      r_dpc4 <= w_pc4;
      if (imem.imem_ready) begin
        r_pc   <= r_pend ? r_pend_pc : w_sel;
        r_pend <= 1'b0;
        r_inst <= imem.imem_inst;
      end else begin
        r_inst <= NOP_INST;
        // Delay slot not yet fetched: park the redirect until it completes.
        if (!r_pend && pcsource != 2'b00) begin
          r_pend    <= 1'b1;
          r_pend_pc <= w_sel;
        end
      end
    end
  end

  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;
  assign dpc4           = r_dpc4;
  assign inst           = r_inst;
  assign pend           = r_pend;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: sequential fetch, branches, stalls,
// wait states with redirect, PC wrap and asynchronous reset.
module tb_pipe_fetch_stage;

  logic        clock;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        wpcir;
  logic        r_ready;
  logic [31:0] pc, dpc4, inst;
  logic        pend;

  int n_checks = 0;
  int n_errors = 0;

  pipe_fetch_stage_if imem_bus ();

  assign imem_bus.imem_ready = r_ready;
  assign imem_bus.imem_inst  = imem_bus.imem_addr | 32'hA000_0000;

  pipe_fetch_stage dut (
    .clock    (clock),
    .resetn   (resetn),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .wpcir    (wpcir),
    .imem     (imem_bus.master),
    .pc       (pc),
    .dpc4     (dpc4),
    .inst     (inst),
    .pend     (pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc,
                        input logic [31:0] e_inst, input logic [31:0] e_dpc4,
                        input logic e_pend);
    check({tag, ".pc"},   pc,   e_pc);
    check({tag, ".inst"}, inst, e_inst);
    check({tag, ".dpc4"}, dpc4, e_dpc4);
    check({tag, ".pend"}, {31'd0, pend}, {31'd0, e_pend});
    check({tag, ".addr"}, imem_bus.imem_addr, e_pc);
  endtask

  initial begin
    resetn   = 1'b0;
    wpcir    = 1'b1;
    r_ready  = 1'b1;
    pcsource = 2'b00;
    bpc      = 32'd0;
    rpc      = 32'd0;
    jpc      = 32'd0;

    #3;
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    #9 resetn = 1'b1;

    // Sequential fetch
    step(); chk_if("seq0", 32'h4, 32'hA000_0000, 32'h4, 1'b0);
    step(); chk_if("seq1", 32'h8, 32'hA000_0004, 32'h8, 1'b0);
    step(); chk_if("seq2", 32'hC, 32'hA000_0008, 32'hC, 1'b0);
    step(); chk_if("seq3", 32'h10, 32'hA000_000C, 32'h10, 1'b0);

    // Branch at 0x10 with delay slot at 0x14
    step(); chk_if("br_in_id", 32'h14, 32'hA000_0010, 32'h14, 1'b0);
    pcsource = 2'b01; bpc = 32'h40;
    step(); chk_if("br_slot", 32'h40, 32'hA000_0014, 32'h18, 1'b0);
    pcsource = 2'b00;
    step(); chk_if("br_tgt", 32'h44, 32'hA000_0040, 32'h44, 1'b0);

    // Jump to 0x20, then decode stall
    pcsource = 2'b11; jpc = 32'h20;
    step(); chk_if("j20", 32'h20, 32'hA000_0044, 32'h48, 1'b0);
    pcsource = 2'b00;
    wpcir = 1'b0; r_ready = 1'b1;
    step(); chk_if("stall0", 32'h20, 32'hA000_0044, 32'h48, 1'b0);
    r_ready = 1'b0; pcsource = 2'b11; jpc = 32'h300;
    step(); chk_if("stall1", 32'h20, 32'hA000_0044, 32'h48, 1'b0);
    wpcir = 1'b1; r_ready = 1'b1; pcsource = 2'b00;
    step(); chk_if("unstall", 32'h24, 32'hA000_0020, 32'h24, 1'b0);

    // jr at 0x2C, delay slot 0x30 waits on memory
    pcsource = 2'b11; jpc = 32'h2C;
    step(); chk_if("j2c", 32'h2C, 32'hA000_0024, 32'h28, 1'b0);
    pcsource = 2'b00;
    step(); chk_if("jr_in_id", 32'h30, 32'hA000_002C, 32'h30, 1'b0);
    pcsource = 2'b10; rpc = 32'h100; r_ready = 1'b0;
    step(); chk_if("wait0", 32'h30, 32'h0, 32'h34, 1'b1);
    pcsource = 2'b11; jpc = 32'h200;
    step(); chk_if("wait1", 32'h30, 32'h0, 32'h34, 1'b1);
    pcsource = 2'b00; r_ready = 1'b1;
    step(); chk_if("redir", 32'h100, 32'hA000_0030, 32'h34, 1'b0);

    // PC wrap
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    step(); chk_if("jtop", 32'hFFFF_FFFC, 32'hA000_0100, 32'h104, 1'b0);
    pcsource = 2'b00;
    step(); chk_if("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    step(); chk_if("post_wrap", 32'h4, 32'hA000_0000, 32'h4, 1'b0);

    // Reset while a redirect is pending
    pcsource = 2'b11; jpc = 32'h80; r_ready = 1'b0;
    step(); chk_if("pend_set", 32'h4, 32'h0, 32'h8, 1'b1);
    #2 resetn = 1'b0;
    #1 chk_if("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    pcsource = 2'b00; r_ready = 1'b1;
    @(posedge clock);
    #2 resetn = 1'b1;
    step(); chk_if("rel0", 32'h4, 32'hA000_0000, 32'h4, 1'b0);
    step(); chk_if("rel1", 32'h8, 32'hA000_0004, 32'h8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
